i2c_reg_poller: RTL
===================

I2C_REG_POLLER -- requirements
Module: i2c_reg_poller

Interface
REQ-001 Parameter DEV_ADDR, default 7'h77, 7-bit I2C slave address.
REQ-002 Parameter NBYTES, default 2, bytes read per transaction; legal range 1..8.
REQ-003 Parameter TIMEOUT, default 65535, cycles allowed per handshake wait before error.
REQ-004 Parameter POLL_DIV, default 1000000, auto-poll period in clk cycles; used only with POLL_TIMER_EN.
REQ-005 clk  input  1  sole clock, all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 trigger  input  1  one-cycle request to read reg_addr.
REQ-008 reg_addr  input  8  start register address, sampled on accepted trigger.
REQ-009 ready  input  1  byte master idle (bus stopped).
REQ-010 start  output  1  held high for the whole framed transaction; falling edge requests STOP.
REQ-011 send / datasend  output  1 / 8  byte-send request and byte.
REQ-012 sended  input  1  byte-send complete pulse.
REQ-013 receive  output  1  byte-receive request.
REQ-014 received / datareceive  input  1 / 8  byte-received pulse and byte.
REQ-015 data  output  8*NBYTES  result, first received byte in MSBs.
REQ-016 valid  output  1  one-cycle pulse when data updated.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 error  output  1  sticky timeout flag.
REQ-019 state  output  4  current FSM state code for debug.

Function
REQ-020 FSM states (code) SHALL be: IDLE 0, WRDY1 1, SEND_AW 2, SEND_REG 3, STOP1 4, WRDY2 5, SEND_AR 6, RECV 7, STOP2 8, DONE 9, ERR 10.
REQ-021 IDLE: trigger=1 latches reg_addr, clears byte counter and error, goes to WRDY1; trigger while busy=1 is ignored.
REQ-022 WRDY1/WRDY2: wait ready=1, then raise start and go to SEND_AW/SEND_AR respectively.
REQ-023 SEND_AW sends {DEV_ADDR,1'b0}; SEND_REG sends latched reg_addr; SEND_AR sends {DEV_ADDR,1'b1}.
REQ-024 Send handshake: send=1 with datasend stable until sended=1 sampled; send=0 for at least one cycle before the next request.
REQ-025 RECV: receive=1 until received=1; datareceive shifted into data shadow; repeats NBYTES times with receive=0 one cycle between bytes.
REQ-026 STOP1/STOP2: start=0, wait ready=1; STOP1 -> WRDY2, STOP2 -> DONE.
REQ-027 DONE: data <= shadow, valid=1 for exactly one cycle, next state IDLE; data holds until next DONE.
REQ-028 Latency: valid asserts in the cycle after the clock edge sampling the final STOP2 ready=1.
REQ-029 Per-state wait counter restarts on each state entry; reaching TIMEOUT in any wait state goes to ERR.
REQ-030 ERR: start, send, receive forced 0, error=1, data unchanged, no valid; returns to IDLE when ready=1.
REQ-031 Byte counter SHALL be 3 bits wide and never wrap past NBYTES-1.
REQ-032 sended/received pulses arriving outside their matching state SHALL be ignored.

Reset
REQ-033 reset=0 forces immediately, regardless of state: state IDLE, start/send/receive/valid/busy/error 0, datasend 0, data 0, counters 0.
REQ-034 Reset mid-transaction abandons it; no valid is produced for it after release.

Configuration
REQ-035 Macro POLL_TIMER_EN: when defined, a free-running counter issues an internal trigger every POLL_DIV cycles using the last accepted reg_addr (0 after reset); ticks while busy are dropped; simultaneous tick and trigger start one transaction with the external reg_addr.
REQ-036 Without POLL_TIMER_EN, no timer logic exists and only external trigger starts transactions.

Verification
REQ-037 NBYTES=1, trigger reg 0xD0, master model returns 0x55 -> datasend sequence 0xEE,0xD0,0xEF; data=0x55; one valid pulse.
REQ-038 NBYTES=2, reg 0xF6, bytes 0x6A then 0x3C -> data=0x6A3C, two receive requests, start low twice (STOP1, STOP2).
REQ-039 TIMEOUT=16, model never pulses sended -> ERR (state 10) after 16 cycles in SEND_AW, error=1, no valid, IDLE once ready=1.
REQ-040 Second trigger with reg 0xAA during RECV -> ignored; latched reg remains 0xF6.
REQ-041 reset=0 during RECV -> all outputs 0 in same cycle, state 0; no valid after release.
REQ-042 With POLL_TIMER_EN, POLL_DIV=100 -> transactions start every 100 cycles with no external trigger; tick during busy is dropped.

Source files
------------

// File: rtl/i2c_reg_poller.sv
// i2c_reg_poller: framed register read (write reg pointer, STOP, read NBYTES).
// Optional auto-poll timer is built when POLL_TIMER_EN is defined.
module i2c_reg_poller #(
  parameter logic [6:0] DEV_ADDR = 7'h77,
  parameter int NBYTES   = 2,
  parameter int TIMEOUT  = 65535,
  parameter int POLL_DIV = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                trigger,
  input  logic [7:0]          reg_addr,
  input  logic                ready,
  output logic                start,
  output logic                send,
  output logic [7:0]          datasend,
  input  logic                sended,
  output logic                receive,
  input  logic                received,
  input  logic [7:0]          datareceive,
  output logic [8*NBYTES-1:0] data,
  output logic                valid,
  output logic                busy,
  output logic                error,
  output logic [3:0]          state
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] WRDY1    = 4'd1;
  localparam logic [3:0] SEND_AW  = 4'd2;
  localparam logic [3:0] SEND_REG = 4'd3;
  localparam logic [3:0] STOP1    = 4'd4;
  localparam logic [3:0] WRDY2    = 4'd5;
  localparam logic [3:0] SEND_AR  = 4'd6;
  localparam logic [3:0] RECV     = 4'd7;
  localparam logic [3:0] STOP2    = 4'd8;
  localparam logic [3:0] DONE     = 4'd9;
  localparam logic [3:0] ERR      = 4'd10;

  localparam int W  = 8 * NBYTES;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM  = TW'(TIMEOUT - 1);
  localparam logic [2:0]    BLAST = 3'(NBYTES - 1);

  if (NBYTES < 1 || NBYTES > 8 || TIMEOUT < 1 || POLL_DIV < 1)
  begin : g_bad_param
    $error("i2c_reg_poller: illegal parameter value");
  end

  logic [7:0]    reg_q;
  logic [W-1:0]  shadow;
  logic [2:0]    bcnt;
  logic [TW-1:0] wcnt;
  logic          go;
  logic [7:0]    nreg;
  logic          adv;
  logic          wst;
  logic          tmo;

`ifdef POLL_TIMER_EN
  localparam int PW = $clog2(POLL_DIV + 1);
  logic [PW-1:0] pcnt;
  logic          tick;

  assign tick = (pcnt == PW'(POLL_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // external request wins and supplies its own address
  assign go   = trigger | tick;
  assign nreg = trigger ? reg_addr : reg_q;
`else
  assign go   = trigger;
  assign nreg = reg_addr;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    adv = 1'b1;
    wst = 1'b1;
    case (state)
      WRDY1, WRDY2, STOP1, STOP2: adv = ready;
      SEND_AW, SEND_REG, SEND_AR: adv = send & sended;
      RECV:                       adv = receive & received;
      default:                    wst = 1'b0;
    endcase
  end

  assign tmo = wst & ~adv & (wcnt == TLIM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      start    <= 1'b0;
      send     <= 1'b0;
      receive  <= 1'b0;
      valid    <= 1'b0;
      error    <= 1'b0;
      datasend <= 8'h00;
      data     <= '0;
      shadow   <= '0;
      reg_q    <= 8'h00;
      bcnt     <= 3'd0;
      wcnt     <= '0;
    end else begin
      valid <= 1'b0;
      if (tmo) begin
        state   <= ERR;
        start   <= 1'b0;
        send    <= 1'b0;
        receive <= 1'b0;
        error   <= 1'b1;
        wcnt    <= '0;
      end else begin
        // any progress (or a non-wait state) restarts the wait budget
        wcnt <= adv ? '0 : wcnt + 1'b1;
        case (state)
          IDLE: begin
            if (go) begin
              reg_q  <= nreg;
              bcnt   <= 3'd0;
              error  <= 1'b0;
              shadow <= '0;
              state  <= WRDY1;
            end
          end
          WRDY1: begin
            if (ready) begin
              start <= 1'b1;
              state <= SEND_AW;
            end
          end
          SEND_AW: begin
            if (!send) begin
              send     <= 1'b1;
              datasend <= {DEV_ADDR, 1'b0};
            end else if (sended) begin
              send  <= 1'b0;
              state <= SEND_REG;
            end
          end
          SEND_REG: begin
            if (!send) begin
              send     <= 1'b1;
              datasend <= reg_q;
            end else if (sended) begin
              send  <= 1'b0;
              start <= 1'b0;
              state <= STOP1;
            end
          end
          STOP1: begin
            if (ready) begin
              state <= WRDY2;
            end
          end
          WRDY2: begin
            if (ready) begin
              start <= 1'b1;
              state <= SEND_AR;
            end
          end
          SEND_AR: begin
            if (!send) begin
              send     <= 1'b1;
              datasend <= {DEV_ADDR, 1'b1};
            end else if (sended) begin
              send  <= 1'b0;
              state <= RECV;
            end
          end
          RECV: begin
            if (!receive) begin
              receive <= 1'b1;
            end else if (received) begin
              receive <= 1'b0;
              shadow  <= (shadow << 8) | W'(datareceive);
              if (bcnt == BLAST) begin
                start <= 1'b0;
                state <= STOP2;
              end else begin
                bcnt <= bcnt + 1'b1;
              end
            end
          end
          STOP2: begin
            if (ready) begin
              data  <= shadow;
              valid <= 1'b1;
              state <= DONE;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          ERR: begin
            if (ready) begin
              state <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
